// File: rtl/reg_slice_pkg.sv
// Shared types for the valid/ready register slice: stage modes and their storage capacity.
package reg_slice_pkg;

  typedef enum logic [1:0] {
    RS_BYPASS,
    RS_FWD,
    RS_BWD,
    RS_FULL
  } rs_mode_e;

  function automatic int unsigned rs_cap(rs_mode_e mode);
    case (mode)
      RS_FWD, RS_BWD: return 1;
      RS_FULL:        return 2;
      default:        return 0;
    endcase
  endfunction

endpackage

// File: rtl/reg_slice_stage.sv
// One valid/ready slice stage; MODE selects bypass, forward, skid (backward) or full registering.
module reg_slice_stage
  import reg_slice_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter rs_mode_e    MODE  = RS_FULL
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             flush,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] dat_o,
  input  logic             ready_o,
  output logic [1:0]       cnt_o
);

  if (MODE == RS_BYPASS) begin : g_bypass
    assign valid_o = valid_i;
    assign dat_o   = dat_i;
    assign ready_i = ready_o;
    assign cnt_o   = 2'd0;

  end else if (MODE == RS_FWD) begin : g_fwd
    logic             m_vld;
    logic [WIDTH-1:0] m_dat;

    assign ready_i = !m_vld || ready_o;
    assign valid_o = m_vld;
    assign dat_o   = m_dat;
    assign cnt_o   = {1'b0, m_vld};

    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        m_vld <= 1'b0;
        m_dat <= '0;
      end else if (flush) begin
        m_vld <= 1'b0;
      end else if (ready_i) begin
        m_vld <= valid_i;
        if (valid_i) m_dat <= dat_i;
      end
    end

  end else if (MODE == RS_BWD) begin : g_bwd
    logic             s_vld;
    logic [WIDTH-1:0] s_dat;

    assign ready_i = !s_vld;
    assign valid_o = s_vld || valid_i;
    assign dat_o   = s_vld ? s_dat : dat_i;
    assign cnt_o   = {1'b0, s_vld};

    // Skid only catches a beat that was accepted upstream but refused downstream.
    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        s_vld <= 1'b0;
        s_dat <= '0;
      end else if (flush) begin
        s_vld <= 1'b0;
      end else if (s_vld) begin
        if (ready_o) s_vld <= 1'b0;
      end else if (valid_i && !ready_o) begin
        s_vld <= 1'b1;
        s_dat <= dat_i;
      end
    end

  end else begin : g_full
    logic             m_vld;
    logic             s_vld;
    logic [WIDTH-1:0] m_dat;
    logic [WIDTH-1:0] s_dat;

    assign ready_i = !s_vld;
    assign valid_o = m_vld;
    assign dat_o   = m_dat;
    assign cnt_o   = {1'b0, m_vld} + {1'b0, s_vld};

    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        m_vld <= 1'b0;
        s_vld <= 1'b0;
        m_dat <= '0;
        s_dat <= '0;
      end else if (flush) begin
        m_vld <= 1'b0;
        s_vld <= 1'b0;
      end else if (s_vld) begin
        // Input is blocked while skid is full; refill main from skid on drain.
        if (ready_o) begin
          m_dat <= s_dat;
          s_vld <= 1'b0;
        end
      end else if (valid_i) begin
        if (!m_vld || ready_o) begin
          m_vld <= 1'b1;
          m_dat <= dat_i;
        end else begin
          s_vld <= 1'b1;
          s_dat <= dat_i;
        end
      end else if (ready_o) begin
        m_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/reg_slice_pipe.sv
// Chain of STAGES identical valid/ready slice stages with a stored-beat level count.
module reg_slice_pipe
  import reg_slice_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 1,
  parameter rs_mode_e    MODE   = RS_FULL,
  localparam int unsigned LVL_W = $clog2(2 * STAGES + 1)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             flush,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] dat_o,
  input  logic             ready_o,
  output logic [LVL_W-1:0] level_o
);

  logic [STAGES:0]  vld;
  logic [STAGES:0]  rdy;
  logic [WIDTH-1:0] dat [STAGES+1];
  logic [1:0]       cnt [STAGES];

  assign vld[0]      = valid_i;
  assign dat[0]      = dat_i;
  assign ready_i     = rdy[0];
  assign valid_o     = vld[STAGES];
  assign dat_o       = dat[STAGES];
  assign rdy[STAGES] = ready_o;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    reg_slice_stage #(
      .WIDTH(WIDTH),
      .MODE (MODE)
    ) u_stage (
      .clk    (clk),
      .arst   (arst),
      .flush  (flush),
      .valid_i(vld[k]),
      .dat_i  (dat[k]),
      .ready_i(rdy[k]),
      .valid_o(vld[k+1]),
      .dat_o  (dat[k+1]),
      .ready_o(rdy[k+1]),
      .cnt_o  (cnt[k])
    );
  end

  always_comb begin
    level_o = '0;
    for (int k = 0; k < STAGES; k++) begin
      level_o = level_o + LVL_W'(cnt[k]);
    end
  end

endmodule

// File: tb/tb_reg_slice_pipe.sv
// Bench for reg_slice_pipe: four configurations sharing stimulus, one observed at a time.
module tb_reg_slice_pipe;
  import reg_slice_pkg::*;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        flush = 1'b0;
  logic        valid_i = 1'b0;
  logic [15:0] dat_i = '0;
  logic        ready_o = 1'b0;

  // 0: FULL x1, 1: BWD x1, 2: FULL x3, 3: FULL x2
  logic        ri [4];
  logic        vo [4];
  logic [15:0] dq [4];
  logic [1:0]  lv0, lv1;
  logic [2:0]  lv2, lv3;

  reg_slice_pipe #(.WIDTH(16), .STAGES(1), .MODE(RS_FULL)) dut0 (
    .clk(clk), .arst(arst), .flush(flush), .valid_i(valid_i), .dat_i(dat_i),
    .ready_i(ri[0]), .valid_o(vo[0]), .dat_o(dq[0]), .ready_o(ready_o), .level_o(lv0));
  reg_slice_pipe #(.WIDTH(16), .STAGES(1), .MODE(RS_BWD)) dut1 (
    .clk(clk), .arst(arst), .flush(flush), .valid_i(valid_i), .dat_i(dat_i),
    .ready_i(ri[1]), .valid_o(vo[1]), .dat_o(dq[1]), .ready_o(ready_o), .level_o(lv1));
  reg_slice_pipe #(.WIDTH(16), .STAGES(3), .MODE(RS_FULL)) dut2 (
    .clk(clk), .arst(arst), .flush(flush), .valid_i(valid_i), .dat_i(dat_i),
    .ready_i(ri[2]), .valid_o(vo[2]), .dat_o(dq[2]), .ready_o(ready_o), .level_o(lv2));
  reg_slice_pipe #(.WIDTH(16), .STAGES(2), .MODE(RS_FULL)) dut3 (
    .clk(clk), .arst(arst), .flush(flush), .valid_i(valid_i), .dat_i(dat_i),
    .ready_i(ri[3]), .valid_o(vo[3]), .dat_o(dq[3]), .ready_o(ready_o), .level_o(lv3));

  always #5 clk = ~clk;

  int          sel = 0;
  logic        ri_s, vo_s;
  logic [15:0] do_s;
  logic [2:0]  lv_s;

  always_comb begin
    ri_s = ri[sel];
    vo_s = vo[sel];
    do_s = dq[sel];
    case (sel)
      0:       lv_s = {1'b0, lv0};
      1:       lv_s = {1'b0, lv1};
      2:       lv_s = lv2;
      default: lv_s = lv3;
    endcase
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  logic [15:0] q[$];
  logic        mon_in_hs = 1'b0;
  int          rcvd = 0;
  int          max_lvl = 2;

  always @(negedge clk) begin
    if (!arst) begin
      mon_in_hs = valid_i && ri_s;
      if (!flush && mon_in_hs) q.push_back(dat_i);
      if (vo_s && ready_o) begin
        if (q.size() == 0) chk("sb_underflow", 1, 0);
        else chk("sb_data", do_s, q.pop_front());
        rcvd++;
      end
      if (flush) q.delete();
      chk("level_max", (int'(lv_s) > max_lvl), 0);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    valid_i = 1'b0; flush = 1'b0; ready_o = 1'b0; arst = 1'b1;
    q.delete();
    @(posedge clk); #1;
    arst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input int pat, input logic [15:0] base, input int mx);
    int sent = 0;
    int cyc = 0;
    int rc0;
    max_lvl = mx;
    valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rc0 = rcvd;
    while ((rcvd - rc0) < n && cyc < 20 * n + 100) begin
      @(posedge clk); #1;
      if (mon_in_hs) sent++;
      valid_i = (sent < n) && (pat == 1 ? 1'b1 : 1'($urandom_range(0, 1)));
      dat_i   = base + 16'(sent);
      ready_o = (pat == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      cyc++;
    end
    chk("stream_beats", rcvd - rc0, n);
    valid_i = 1'b0;
    ready_o = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("stream_queue_empty", q.size(), 0);
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        r;
    logic        f;
    logic        eri;
    logic        evo;
    logic [15:0] edo;
    logic [2:0]  elv;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 16'hAAAA, 0, 0, 1, 0, 16'h0000, 0};
    tbl[1]  = '{1, 16'hBBBB, 0, 0, 1, 1, 16'hAAAA, 1};
    tbl[2]  = '{1, 16'hCCCC, 0, 0, 0, 1, 16'hAAAA, 2};
    tbl[3]  = '{1, 16'hCCCC, 1, 0, 0, 1, 16'hAAAA, 2};
    tbl[4]  = '{1, 16'hCCCC, 1, 0, 1, 1, 16'hBBBB, 1};
    tbl[5]  = '{0, 16'h0000, 1, 0, 1, 1, 16'hCCCC, 1};
    tbl[6]  = '{0, 16'h0000, 1, 0, 1, 0, 16'hCCCC, 0};
    tbl[7]  = '{1, 16'h1111, 0, 0, 1, 0, 16'hCCCC, 0};
    tbl[8]  = '{1, 16'h2222, 0, 0, 1, 1, 16'h1111, 1};
    tbl[9]  = '{0, 16'h0000, 0, 1, 0, 1, 16'h1111, 2};
    tbl[10] = '{0, 16'h0000, 0, 0, 1, 0, 16'h1111, 0};

    // Reset values, with a beat presented during reset.
    valid_i = 1'b1; dat_i = 16'hBEEF;
    repeat (2) @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++) chk($sformatf("rst_ready_i[%0d]", i), ri[i], 1);
    chk("rst_valid_o_full1", vo[0], 0);
    chk("rst_valid_o_bwd", vo[1], 1);
    chk("rst_dat_o_bwd", dq[1], 16'hBEEF);
    chk("rst_valid_o_full3", vo[2], 0);
    chk("rst_level", {lv0, lv1, lv2, lv3}, 0);
    valid_i = 1'b0;
    @(posedge clk); #1;
    arst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_not_stored", lv0, 0);

    // FULL x1 table: stall, skid, replace-on-drain, flush.
    sel = 0;
    max_lvl = 2;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      valid_i = tbl[i].v; dat_i = tbl[i].d; ready_o = tbl[i].r; flush = tbl[i].f;
      #2;
      chk($sformatf("tbl%0d_ready_i", i), ri_s, tbl[i].eri);
      chk($sformatf("tbl%0d_valid_o", i), vo_s, tbl[i].evo);
      chk($sformatf("tbl%0d_dat_o", i), do_s, tbl[i].edo);
      chk($sformatf("tbl%0d_level", i), lv_s, tbl[i].elv);
    end
    flush = 1'b0;

    // FULL x1 streaming: 1-cycle latency, one beat per cycle.
    do_reset();
    sel = 0;
    max_lvl = 2;
    ready_o = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      valid_i = 1'b1; dat_i = 16'(i);
      #2;
      if (i > 1) begin
        chk("strm_valid_o", vo_s, 1);
        chk("strm_dat_o", do_s, 16'(i - 1));
        chk("strm_level", lv_s, 1);
      end
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    #2;
    chk("strm_last", do_s, 16'h0010);

    // BWD with ready toggling 1,0,1,0.
    do_reset();
    sel = 1;
    stream(8, 1, 16'h0000, 1);

    // FULL x3 random traffic.
    do_reset();
    sel = 2;
    stream(1000, 0, 16'h4000, 6);

    // FULL x3 unstalled latency.
    ready_o = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b1; dat_i = 16'h5A5A;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        valid_i = 1'b0;
      end
      #2;
      chk($sformatf("lat3_valid_k%0d", k), vo_s, (k == 3));
    end
    chk("lat3_dat", do_s, 16'h5A5A);

    // FULL x2: fill to 4, flush, then a fresh beat after 2 cycles.
    do_reset();
    sel = 3;
    max_lvl = 4;
    ready_o = 1'b0;
    begin
      int cyc = 0;
      while (lv_s != 3'd4 && cyc < 20) begin
        @(posedge clk); #1;
        valid_i = 1'b1; dat_i = 16'h0F00 + 16'(cyc);
        #2;
        cyc++;
      end
      chk("flush_fill_level", lv_s, 4);
    end
    @(posedge clk); #1;
    valid_i = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("flush_level", lv_s, 0);
    chk("flush_valid_o", vo_s, 0);
    chk("flush_ready_i", ri_s, 1);
    ready_o = 1'b1; valid_i = 1'b1; dat_i = 16'h1234;
    for (int k = 0; k <= 2; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        valid_i = 1'b0;
      end
      #2;
      chk($sformatf("flush_next_valid_k%0d", k), vo_s, (k == 2));
    end
    chk("flush_next_dat", do_s, 16'h1234);

    // FULL x3: async reset mid-stream, then resume.
    do_reset();
    sel = 2;
    max_lvl = 6;
    ready_o = 1'b0;
    begin
      int cyc = 0;
      while (lv_s != 3'd3 && cyc < 20) begin
        @(posedge clk); #1;
        valid_i = 1'b1; dat_i = 16'h7700 + 16'(cyc);
        #2;
        cyc++;
      end
      chk("arst_fill_level", lv_s, 3);
    end
    arst = 1'b1;
    #1;
    chk("arst_valid_o", vo_s, 0);
    chk("arst_level", lv_s, 0);
    chk("arst_ready_i", ri_s, 1);
    q.delete();
    valid_i = 1'b0;
    @(posedge clk); #1;
    arst = 1'b0;
    stream(20, 0, 16'h9000, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
